mem_bus_master: RTL and testbench

Bus initiator for the matrix engine's shared memory bus. It accepts single read or write commands from a client (EXE or ALU sequencing logic) through a valid/ready handshake. It drives the 16-bit address bus, the read/write strobes and the memory input data bus, captures read data from the memory output bus, and returns one response per command. It sits between the execution sequencer and the memory module, and only accesses the memory module.

---
 rtl/mem_bus_master.sv | 122 ++++++++++++
 tb/tb_mem_bus_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// ============================================================================
// Module      : mem_bus_master
// Description : Single-outstanding bus initiator between the execution
//               sequencer and the shared memory module.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_master #(
  parameter int          DATA_WIDTH  = 256,
  parameter logic [3:0]  MEM_SELECT  = 4'h1,
  parameter logic [3:0]  IDLE_SELECT = 4'hF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic                  cmdWrite,
  input  logic [2:0]            cmdIndex,
  input  logic [DATA_WIDTH-1:0] cmdWriteData,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic                  rspWrite,
  output logic [DATA_WIDTH-1:0] rspData,
  output logic [15:0]           addressBus,
  output logic [DATA_WIDTH-1:0] inputDataBus,
  input  logic [DATA_WIDTH-1:0] outputDataBus,
  output logic                  readFromMem,
  output logic                  writeToMem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [15:0] c_IDLE_ADDR = {IDLE_SELECT, 12'h000};

  state_t                r_state;
  state_t                w_nextState;
  logic                  w_accept;
  logic                  r_readStrobe;
  logic                  r_writeStrobe;
  logic                  r_rspValid;
  logic                  r_rspWrite;
  logic [DATA_WIDTH-1:0] r_rspData;
  logic [15:0]           r_addressBus;
  logic [DATA_WIDTH-1:0] r_inputDataBus;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = cmdValid;
        if (cmdValid) w_nextState = S_ISSUE;
      end
      S_ISSUE: w_nextState = r_rspWrite ? S_RESP : S_WAIT;
      S_WAIT:  w_nextState = S_RESP;
      S_RESP:  if (rspReady) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Bus and response registers; strobes only ever live for the ISSUE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_readStrobe   <= 1'b0;
      r_writeStrobe  <= 1'b0;
      r_rspValid     <= 1'b0;
      r_rspWrite     <= 1'b0;
      r_rspData      <= '0;
      r_addressBus   <= c_IDLE_ADDR;
      r_inputDataBus <= '0;
    end else begin
      r_readStrobe  <= 1'b0;
      r_writeStrobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addressBus  <= {MEM_SELECT, 4'h0, 1'b0, cmdIndex, 4'h0};
            r_readStrobe  <= ~cmdWrite;
            r_writeStrobe <= cmdWrite;
            r_rspWrite    <= cmdWrite;
            if (cmdWrite) r_inputDataBus <= cmdWriteData;
          end
        end
        S_ISSUE: begin
          r_addressBus <= c_IDLE_ADDR;
          if (r_rspWrite) r_rspValid <= 1'b1;
        end
        S_WAIT: begin
          r_rspData  <= outputDataBus;
          r_rspValid <= 1'b1;
        end
        S_RESP: begin
          if (rspReady) r_rspValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cmdReady     = (r_state == S_IDLE);
  assign rspValid     = r_rspValid;
  assign rspWrite     = r_rspWrite;
  assign rspData      = r_rspData;
  assign addressBus   = r_addressBus;
  assign inputDataBus = r_inputDataBus;
  assign readFromMem  = r_readStrobe;
  assign writeToMem   = r_writeStrobe;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_master.sv
// ============================================================================
// Module      : tb_mem_bus_master
// Description : Directed self-checking bench for mem_bus_master with an
//               eight-word memory model on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_master;

  localparam int          DW  = 256;
  localparam logic [DW-1:0] c_A5  = {32{8'hA5}};
  localparam logic [DW-1:0] c_PRE = 256'h0017_002d_0043_0059_006f_0085_009b_00b1_00c7_00dd_00f3_0109_011f_0135_014b_0013;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmdValid;
  logic          cmdReady;
  logic          cmdWrite;
  logic [2:0]    cmdIndex;
  logic [DW-1:0] cmdWriteData;
  logic          rspValid;
  logic          rspReady;
  logic          rspWrite;
  logic [DW-1:0] rspData;
  logic [15:0]   addressBus;
  logic [DW-1:0] inputDataBus;
  logic [DW-1:0] outputDataBus;
  logic          readFromMem;
  logic          writeToMem;
  logic          preload;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [0:7];

  always #5 clk = ~clk;

  mem_bus_master #(.DATA_WIDTH(DW), .MEM_SELECT(4'h1), .IDLE_SELECT(4'hF)) dut (
    .clk(clk), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
    .cmdIndex(cmdIndex), .cmdWriteData(cmdWriteData),
    .rspValid(rspValid), .rspReady(rspReady), .rspWrite(rspWrite), .rspData(rspData),
    .addressBus(addressBus), .inputDataBus(inputDataBus), .outputDataBus(outputDataBus),
    .readFromMem(readFromMem), .writeToMem(writeToMem)
  );

  // Memory samples strobes at the edge that ends the strobe cycle; read data appears after it.
  always @(posedge clk) begin
    if (preload) mem[1] <= c_PRE;
    if (writeToMem && addressBus[15:12] == 4'h1) mem[addressBus[6:4]] <= inputDataBus;
    if (readFromMem && addressBus[15:12] == 4'h1) outputDataBus <= mem[addressBus[6:4]];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdIndex = 3'd2; cmdWriteData = '1;
    step;
    cmdValid = 1'b0;
    #3 reset = 1'b0;
    #1;
    total++; if (cmdReady !== 1'b1) begin bad++; $display("FAIL rst_cmdReady: got %b want 1", cmdReady); end
    total++; if (rspValid !== 1'b0) begin bad++; $display("FAIL rst_rspValid: got %b want 0", rspValid); end
    total++; if (rspWrite !== 1'b0) begin bad++; $display("FAIL rst_rspWrite: got %b want 0", rspWrite); end
    total++; if (rspData !== '0) begin bad++; $display("FAIL rst_rspData: got %h want 0", rspData); end
    total++; if (addressBus !== 16'hF000) begin bad++; $display("FAIL rst_addr: got %h want f000", addressBus); end
    total++; if (inputDataBus !== '0) begin bad++; $display("FAIL rst_inData: got %h want 0", inputDataBus); end
    total++; if (readFromMem !== 1'b0 || writeToMem !== 1'b0) begin bad++; $display("FAIL rst_strobes: got r=%b w=%b want 0 0", readFromMem, writeToMem); end
    step;
    reset = 1'b1;
    step;
    total++; if (cmdReady !== 1'b1 || rspValid !== 1'b0) begin bad++; $display("FAIL rst_after: got rdy=%b vld=%b want 1 0", cmdReady, rspValid); end
  endtask

  task automatic test_write_read;
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdIndex = 3'd5; cmdWriteData = c_A5;
    step;
    cmdValid = 1'b0;
    total++; if (writeToMem !== 1'b1 || readFromMem !== 1'b0) begin bad++; $display("FAIL wr_strobe: got r=%b w=%b want 0 1", readFromMem, writeToMem); end
    total++; if (addressBus !== 16'h1050) begin bad++; $display("FAIL wr_addr: got %h want 1050", addressBus); end
    total++; if (inputDataBus !== c_A5) begin bad++; $display("FAIL wr_inData: got %h want %h", inputDataBus, c_A5); end
    total++; if (rspValid !== 1'b0 || cmdReady !== 1'b0) begin bad++; $display("FAIL wr_issue: got vld=%b rdy=%b want 0 0", rspValid, cmdReady); end
    step;
    total++; if (writeToMem !== 1'b0 || addressBus !== 16'hF000) begin bad++; $display("FAIL wr_release: got w=%b addr=%h want 0 f000", writeToMem, addressBus); end
    total++; if (rspValid !== 1'b1 || rspWrite !== 1'b1) begin bad++; $display("FAIL wr_rsp: got vld=%b wr=%b want 1 1", rspValid, rspWrite); end
    rspReady = 1'b1;
    step;
    rspReady = 1'b0;
    total++; if (rspValid !== 1'b0 || cmdReady !== 1'b1) begin bad++; $display("FAIL wr_done: got vld=%b rdy=%b want 0 1", rspValid, cmdReady); end

    cmdValid = 1'b1; cmdWrite = 1'b0; cmdIndex = 3'd5; cmdWriteData = '0;
    step;
    cmdValid = 1'b0;
    total++; if (readFromMem !== 1'b1 || writeToMem !== 1'b0 || addressBus !== 16'h1050) begin bad++; $display("FAIL rd_issue: got r=%b w=%b addr=%h want 1 0 1050", readFromMem, writeToMem, addressBus); end
    step;
    total++; if (readFromMem !== 1'b0 || rspValid !== 1'b0) begin bad++; $display("FAIL rd_wait: got r=%b vld=%b want 0 0", readFromMem, rspValid); end
    step;
    total++; if (rspValid !== 1'b1 || rspWrite !== 1'b0) begin bad++; $display("FAIL rd_rsp: got vld=%b wr=%b want 1 0", rspValid, rspWrite); end
    total++; if (rspData !== c_A5) begin bad++; $display("FAIL rd_data: got %h want %h", rspData, c_A5); end
    total++; if (inputDataBus !== c_A5) begin bad++; $display("FAIL rd_inData_hold: got %h want %h", inputDataBus, c_A5); end
    rspReady = 1'b1;
    step;
    rspReady = 1'b0;
    total++; if (rspValid !== 1'b0 || cmdReady !== 1'b1) begin bad++; $display("FAIL rd_done: got vld=%b rdy=%b want 0 1", rspValid, cmdReady); end
  endtask

  task automatic test_preload;
    preload = 1'b1;
    step;
    preload = 1'b0;
    rspReady = 1'b1;
    cmdValid = 1'b1; cmdWrite = 1'b0; cmdIndex = 3'd1;
    step;
    cmdValid = 1'b0;
    total++; if (addressBus !== 16'h1010 || readFromMem !== 1'b1) begin bad++; $display("FAIL pre_issue: got addr=%h r=%b want 1010 1", addressBus, readFromMem); end
    step;
    step;
    total++; if (rspValid !== 1'b1 || rspData !== c_PRE) begin bad++; $display("FAIL pre_data: got vld=%b data=%h want 1 %h", rspValid, rspData, c_PRE); end
    total++; if (inputDataBus !== c_A5) begin bad++; $display("FAIL pre_inData: got %h want %h", inputDataBus, c_A5); end
    step;
    rspReady = 1'b0;
    total++; if (rspValid !== 1'b0 || cmdReady !== 1'b1) begin bad++; $display("FAIL pre_done: got vld=%b rdy=%b want 0 1", rspValid, cmdReady); end
  endtask

  task automatic test_backpressure;
    cmdValid = 1'b1; cmdWrite = 1'b0; cmdIndex = 3'd5;
    step;
    cmdValid = 1'b0;
    step;
    step;
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdIndex = 3'd7; cmdWriteData = {8{32'hDEAD_BEEF}};
    for (int k = 0; k < 5; k++) begin
      total++; if (rspValid !== 1'b1 || rspData !== c_A5 || rspWrite !== 1'b0) begin bad++; $display("FAIL bp_hold%0d: got vld=%b wr=%b data=%h want 1 0 %h", k, rspValid, rspWrite, rspData, c_A5); end
      total++; if (cmdReady !== 1'b0 || readFromMem !== 1'b0 || writeToMem !== 1'b0) begin bad++; $display("FAIL bp_idle%0d: got rdy=%b r=%b w=%b want 0 0 0", k, cmdReady, readFromMem, writeToMem); end
      step;
    end
    cmdValid = 1'b0;
    total++; if (inputDataBus !== c_A5) begin bad++; $display("FAIL bp_inData: got %h want %h", inputDataBus, c_A5); end
    rspReady = 1'b1;
    step;
    rspReady = 1'b0;
    total++; if (rspValid !== 1'b0 || cmdReady !== 1'b1) begin bad++; $display("FAIL bp_done: got vld=%b rdy=%b want 0 1", rspValid, cmdReady); end
  endtask

  task automatic test_reset_in_wait;
    cmdValid = 1'b1; cmdWrite = 1'b0; cmdIndex = 3'd5;
    step;
    cmdValid = 1'b0;
    step;
    #3 reset = 1'b0;
    #1;
    total++; if (rspValid !== 1'b0 || readFromMem !== 1'b0 || writeToMem !== 1'b0 || addressBus !== 16'hF000) begin bad++; $display("FAIL rw_reset: got vld=%b r=%b w=%b addr=%h want 0 0 0 f000", rspValid, readFromMem, writeToMem, addressBus); end
    step;
    reset = 1'b1;
    step;
    step;
    total++; if (rspValid !== 1'b0 || cmdReady !== 1'b1) begin bad++; $display("FAIL rw_norsp: got vld=%b rdy=%b want 0 1", rspValid, cmdReady); end
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdIndex = 3'd3; cmdWriteData = {16{16'h3C3C}};
    step;
    cmdValid = 1'b0;
    total++; if (writeToMem !== 1'b1 || addressBus !== 16'h1030) begin bad++; $display("FAIL rw_wr_issue: got w=%b addr=%h want 1 1030", writeToMem, addressBus); end
    step;
    total++; if (rspValid !== 1'b1 || rspWrite !== 1'b1 || writeToMem !== 1'b0) begin bad++; $display("FAIL rw_wr_rsp: got vld=%b wr=%b w=%b want 1 1 0", rspValid, rspWrite, writeToMem); end
    rspReady = 1'b1;
    step;
    rspReady = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] d;
    logic [15:0]   ea;
    rspReady = 1'b1;
    cmdValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d  = {8{32'hC0DE_0000 | 32'(i)}};
      ea = 16'h1000 | (16'(i) << 4);
      cmdWrite = 1'b1; cmdIndex = 3'(i); cmdWriteData = d;
      step;
      total++; if (writeToMem !== 1'b1 || readFromMem !== 1'b0 || addressBus !== ea) begin bad++; $display("FAIL b2b_wr%0d: got r=%b w=%b addr=%h want 0 1 %h", i, readFromMem, writeToMem, addressBus, ea); end
      step;
      total++; if (rspValid !== 1'b1 || rspWrite !== 1'b1 || writeToMem !== 1'b0) begin bad++; $display("FAIL b2b_wrsp%0d: got vld=%b wr=%b w=%b want 1 1 0", i, rspValid, rspWrite, writeToMem); end
      step;
      total++; if (cmdReady !== 1'b1 || rspValid !== 1'b0) begin bad++; $display("FAIL b2b_wdone%0d: got rdy=%b vld=%b want 1 0", i, cmdReady, rspValid); end
      cmdWrite = 1'b0; cmdWriteData = '0;
      step;
      total++; if (readFromMem !== 1'b1 || writeToMem !== 1'b0 || addressBus !== ea) begin bad++; $display("FAIL b2b_rd%0d: got r=%b w=%b addr=%h want 1 0 %h", i, readFromMem, writeToMem, addressBus, ea); end
      step;
      total++; if (readFromMem !== 1'b0 || rspValid !== 1'b0) begin bad++; $display("FAIL b2b_rwait%0d: got r=%b vld=%b want 0 0", i, readFromMem, rspValid); end
      step;
      total++; if (rspValid !== 1'b1 || rspWrite !== 1'b0 || rspData !== d) begin bad++; $display("FAIL b2b_rrsp%0d: got vld=%b wr=%b data=%h want 1 0 %h", i, rspValid, rspWrite, rspData, d); end
      step;
      total++; if (cmdReady !== 1'b1 || rspValid !== 1'b0) begin bad++; $display("FAIL b2b_rdone%0d: got rdy=%b vld=%b want 1 0", i, cmdReady, rspValid); end
    end
    cmdValid = 1'b0;
    rspReady = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cmdValid = 1'b0; cmdWrite = 1'b0; cmdIndex = 3'd0; cmdWriteData = '0;
    rspReady = 1'b0; preload = 1'b0;
    step;
    step;
    reset = 1'b1;
    step;
    test_reset;
    test_write_read;
    test_preload;
    test_backpressure;
    test_reset_in_wait;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
